// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and helpers for the 10G PHY 64b/66b transmit and receive paths.
package eth_phy_10g_pkg;

    localparam logic [1:0]  SYNC_DATA       = 2'b01;
    localparam logic [1:0]  SYNC_CTRL       = 2'b10;
    localparam logic [7:0]  BLOCK_TYPE_IDLE = 8'h1E;

    localparam int unsigned SCR_WIDTH = 58;
    localparam int unsigned SCR_TAP_A = 38;
    localparam int unsigned SCR_TAP_B = 57;
    localparam logic [57:0] SCR_INIT  = 58'h3FF_FFFF_FFFF_FFFF;

    localparam int unsigned GEARBOX_PERIOD = 33;
    localparam logic [5:0]  SEQ_PAUSE      = 6'(GEARBOX_PERIOD - 1);

    // Kind of gearbox cycle: one block consumed, or residual flushed
    typedef enum logic [0:0] {
        SLOT_BLOCK,
        SLOT_PAUSE
    } slot_e;

    // A sync header is legal only as 01 (data) or 10 (control)
    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_tx_scrambler.sv
// Parallel self-synchronous scrambler, x^58 + x^39 + 1, DATA_WIDTH bits per cycle.
// Bit 0 is the first bit on the line; the state only moves when i_advance is high.
module eth_phy_10g_tx_scrambler
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_advance,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [SCR_WIDTH-1:0] state;
    logic [SCR_WIDTH-1:0] state_next;

    // Unroll the serial LFSR across the whole word; each scrambled bit feeds the next
    always_comb begin
        logic [SCR_WIDTH-1:0] st;
        st     = state;
        o_data = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            o_data[i] = i_data[i] ^ st[SCR_TAP_A] ^ st[SCR_TAP_B];
            st        = {st[SCR_WIDTH-2:0], o_data[i]};
        end
        state_next = st;
    end

    // State register, advanced once per consumed block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCR_INIT;
        end else if (i_advance) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 10G PHY transmit gearbox: scrambles 66-bit blocks and packs them into a
// continuous 64-bit SerDes stream, 32 blocks per 33 words, inserting idles
// whenever upstream has nothing to send.
module eth_phy_10g_tx_gearbox
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int SERDES_WIDTH      = 64,
    parameter int SCRAMBLER_DISABLE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   i_tx_data,
    input  logic [HDR_WIDTH-1:0]    i_tx_hdr,
    input  logic                    i_tx_valid,
    output logic                    o_tx_ready,
    output logic [SERDES_WIDTH-1:0] o_serdes_tx,
    output logic                    o_tx_underflow,
    output logic                    o_tx_hdr_err
);

    localparam int unsigned BLOCK_WIDTH = DATA_WIDTH + HDR_WIDTH;
    localparam int unsigned MERGE_WIDTH = 2 * SERDES_WIDTH;
    localparam logic [DATA_WIDTH-1:0] IDLE_PAYLOAD = DATA_WIDTH'(BLOCK_TYPE_IDLE);

    logic [5:0]              seq;
    slot_e                   slot;
    logic [SERDES_WIDTH-1:0] residual;
    logic [HDR_WIDTH-1:0]    blk_hdr;
    logic [DATA_WIDTH-1:0]   blk_payload;
    logic [DATA_WIDTH-1:0]   scr_payload;
    logic [DATA_WIDTH-1:0]   tx_payload;
    logic [BLOCK_WIDTH-1:0]  blk;
    logic [5:0]              shamt;
    logic [MERGE_WIDTH-1:0]  merged;

    assign slot       = (seq == SEQ_PAUSE) ? SLOT_PAUSE : SLOT_BLOCK;
    assign o_tx_ready = (slot == SLOT_BLOCK);

    // Pick the offered block, or an idle control block when upstream is empty
    always_comb begin
        blk_hdr     = SYNC_CTRL;
        blk_payload = IDLE_PAYLOAD;
        if (i_tx_valid) begin
            blk_hdr     = i_tx_hdr;
            blk_payload = i_tx_data;
        end
    end

    eth_phy_10g_tx_scrambler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_scrambler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (slot == SLOT_BLOCK),
        .i_data    (blk_payload),
        .o_data    (scr_payload)
    );

    assign tx_payload = (SCRAMBLER_DISABLE != 0) ? blk_payload : scr_payload;
    assign blk        = {tx_payload, blk_hdr};

    // Residual holds 2*seq bits before slot seq; the new block lands right above them
    assign shamt = {seq[4:0], 1'b0};

    // Merge residual (sent first) with the new block; low half goes out, high half stays
    always_comb begin
        merged = ({{(MERGE_WIDTH - BLOCK_WIDTH){1'b0}}, blk} << shamt)
               | {{SERDES_WIDTH{1'b0}}, residual};
    end

    // Sequence counter, residual buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq            <= '0;
            residual       <= '0;
            o_serdes_tx    <= '0;
            o_tx_underflow <= 1'b0;
            o_tx_hdr_err   <= 1'b0;
        end else if (slot == SLOT_PAUSE) begin
            seq            <= '0;
            residual       <= '0;
            o_serdes_tx    <= residual;
            o_tx_underflow <= 1'b0;
            o_tx_hdr_err   <= 1'b0;
        end else begin
            seq            <= seq + 6'd1;
            residual       <= merged[MERGE_WIDTH-1:SERDES_WIDTH];
            o_serdes_tx    <= merged[SERDES_WIDTH-1:0];
            o_tx_underflow <= !i_tx_valid;
            o_tx_hdr_err   <= i_tx_valid && !hdr_is_valid(i_tx_hdr);
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Bench for the 10G TX gearbox: one unscrambled and one scrambled instance share
// the same stimulus. The reference model is a bit FIFO: each consumed block pushes
// its 66 line bits, each cycle pops 64; ready is "fewer than 64 bits waiting".
module tb_eth_phy_10g_tx_gearbox;
    import eth_phy_10g_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] tx_data = '0;
    logic [1:0]  tx_hdr = '0;
    logic        tx_valid = 1'b0;

    logic        rdy_r, rdy_s, uf_r, uf_s, err_r, err_s;
    logic [63:0] word_r, word_s;

    always #5 clk = ~clk;

    eth_phy_10g_tx_gearbox #(
        .DATA_WIDTH(64), .HDR_WIDTH(2), .SERDES_WIDTH(64), .SCRAMBLER_DISABLE(1)
    ) dut_raw (
        .clk(clk), .rst_n(rst_n), .i_tx_data(tx_data), .i_tx_hdr(tx_hdr),
        .i_tx_valid(tx_valid), .o_tx_ready(rdy_r), .o_serdes_tx(word_r),
        .o_tx_underflow(uf_r), .o_tx_hdr_err(err_r)
    );

    eth_phy_10g_tx_gearbox #(
        .DATA_WIDTH(64), .HDR_WIDTH(2), .SERDES_WIDTH(64), .SCRAMBLER_DISABLE(0)
    ) dut_scr (
        .clk(clk), .rst_n(rst_n), .i_tx_data(tx_data), .i_tx_hdr(tx_hdr),
        .i_tx_valid(tx_valid), .o_tx_ready(rdy_s), .o_serdes_tx(word_s),
        .o_tx_underflow(uf_s), .o_tx_hdr_err(err_s)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // reference model state
    logic        q_r[$];
    logic        q_s[$];
    logic [57:0] m_scr;
    logic [65:0] sent[$];
    // captured DUT line bits since the last reset
    logic        rx_r[$];
    logic        rx_s[$];
    int unsigned dut_lows;
    int unsigned dut_ufs;

    typedef struct {
        logic        v;
        logic [1:0]  h;
        logic [63:0] d;
        logic [63:0] w;
        logic        uf;
        logic        err;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_r.delete(); q_s.delete(); sent.delete(); rx_r.delete(); rx_s.delete();
        m_scr = SCR_INIT;
    endtask

    // Drive one cycle of stimulus, advance the model, check both instances after the edge
    task automatic cycle(input logic v, input logic [1:0] h, input logic [63:0] d);
        logic        exp_rdy, exp_uf, exp_err, s;
        logic [1:0]  bh;
        logic [63:0] bd, ew_r, ew_s;
        tx_valid = v; tx_hdr = h; tx_data = d;
        exp_rdy = (q_r.size() != 64);
        chk("ready_raw", 66'(rdy_r), 66'(exp_rdy));
        chk("ready_scr", 66'(rdy_s), 66'(exp_rdy));
        if (!rdy_r) dut_lows++;
        exp_uf = 1'b0; exp_err = 1'b0;
        if (exp_rdy) begin
            if (v) begin bh = h; bd = d; end
            else begin bh = SYNC_CTRL; bd = 64'h1E; exp_uf = 1'b1; end
            exp_err = v && (h == 2'b00 || h == 2'b11);
            sent.push_back({bd, bh});
            q_r.push_back(bh[0]); q_r.push_back(bh[1]);
            q_s.push_back(bh[0]); q_s.push_back(bh[1]);
            for (int i = 0; i < 64; i++) begin
                q_r.push_back(bd[i]);
                s = bd[i] ^ m_scr[38] ^ m_scr[57];
                m_scr = {m_scr[56:0], s};
                q_s.push_back(s);
            end
        end
        for (int i = 0; i < 64; i++) begin
            ew_r[i] = q_r.pop_front();
            ew_s[i] = q_s.pop_front();
        end
        @(posedge clk); #1;
        chk("word_raw", 66'(word_r), 66'(ew_r));
        chk("word_scr", 66'(word_s), 66'(ew_s));
        chk("uflow_raw", 66'(uf_r), 66'(exp_uf));
        chk("uflow_scr", 66'(uf_s), 66'(exp_uf));
        chk("hdrerr_raw", 66'(err_r), 66'(exp_err));
        chk("hdrerr_scr", 66'(err_s), 66'(exp_err));
        if (uf_r) dut_ufs++;
        for (int i = 0; i < 64; i++) begin
            rx_r.push_back(word_r[i]);
            rx_s.push_back(word_s[i]);
        end
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release on the falling edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_word_raw", 66'(word_r), '0);
        chk("rst_word_scr", 66'(word_s), '0);
        chk("rst_uflow", 66'({uf_r, uf_s}), '0);
        chk("rst_hdrerr", 66'({err_r, err_s}), '0);
        chk("rst_ready", 66'({rdy_r, rdy_s}), 66'(2'b11));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        dut_lows = 0;
        dut_ufs  = 0;
    endtask

    // Independent descrambler over the captured scrambled stream, block-aligned from reset
    task automatic descramble_check(input int unsigned min_blocks);
        logic [57:0] st;
        logic [1:0]  h;
        logic [63:0] p;
        logic        r;
        int unsigned n = 0;
        st = SCR_INIT;
        while (rx_s.size() >= 66 && sent.size() > 0) begin
            h[0] = rx_s.pop_front();
            h[1] = rx_s.pop_front();
            for (int i = 0; i < 64; i++) begin
                r = rx_s.pop_front();
                p[i] = r ^ st[38] ^ st[57];
                st = {st[56:0], r};
            end
            chk("descrambled_block", {p, h}, sent.pop_front());
            n++;
        end
        chk("descrambled_count_ok", 66'(n >= min_blocks), 66'(1));
    endtask

    // Slip-search block lock on the raw stream starting at a random bit offset
    task automatic lock_check();
        int unsigned rot, p, good, blocks;
        logic        locked;
        rot = $urandom_range(1, 65);
        p = rot; good = 0; blocks = 0; locked = 1'b0;
        while (!locked && (p + 66 <= rx_r.size()) && blocks < 66 * 64) begin
            blocks++;
            if (rx_r[p] != rx_r[p + 1]) begin
                good++;
                p += 66;
                if (good == 64) locked = 1'b1;
            end else begin
                good = 0;
                p += 67;
            end
        end
        chk("far_end_lock", 66'(locked), 66'(1));
        chk("far_end_lock_offset", 66'(p % 66), '0);
    endtask

    initial begin
        logic [63:0] idx;
        logic        v;
        logic [1:0]  h;
        int unsigned r;

        // slot-by-slot expectations for the unscrambled instance right after reset
        vt[0] = '{1'b1, 2'b01, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_000D, 1'b0, 1'b0};
        vt[1] = '{1'b1, 2'b10, 64'hC000_0000_0000_0001, 64'h0000_0000_0000_0018, 1'b0, 1'b0};
        vt[2] = '{1'b0, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_07AC, 1'b1, 1'b0};
        vt[3] = '{1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 1'b1};
        vt[4] = '{1'b1, 2'b01, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_01FF, 1'b0, 1'b0};

        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(vt[i].v, vt[i].h, vt[i].d);
            chk("vec_word", 66'(word_r), 66'(vt[i].w));
            chk("vec_uflow", 66'(uf_r), 66'(vt[i].uf));
            chk("vec_hdrerr", 66'(err_r), 66'(vt[i].err));
        end

        // continuous indexed stream with two idle slots, ten gearbox periods
        do_reset();
        idx = '0;
        for (int c = 0; c < 330; c++) begin
            v = !(c == 5 || c == 6);
            cycle(v, SYNC_DATA, idx);
            if (v && (c % 33) != 32) idx++;
        end
        chk("ready_low_count", 66'(dut_lows), 66'(10));
        chk("underflow_count", 66'(dut_ufs), 66'(2));

        // all-zero payloads through the scrambler
        do_reset();
        for (int c = 0; c < 215; c++) cycle(1'b1, SYNC_DATA, '0);
        descramble_check(200);

        // random traffic with bad headers, gaps and a mid-stream reset
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 150) do_reset();
            r = $urandom_range(0, 9);
            h = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 6) ? SYNC_DATA : SYNC_CTRL;
            cycle($urandom_range(0, 9) != 0, h, {$urandom, $urandom});
        end
        descramble_check(200);

        // far-end lock on a stream of legal random blocks
        do_reset();
        for (int c = 0; c < 700; c++) begin
            h = ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL;
            cycle(1'b1, h, {$urandom, $urandom});
        end
        lock_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_tx_gearbox.md
Name: eth_phy_10g_tx_gearbox

Overview:
Transmit-side counterpart of the 10G PHY RX frame aligner. Accepts one 66-bit block per cycle as a 64-bit payload plus a 2-bit sync header, scrambles the payload, and packs blocks into a continuous 64-bit SerDes word stream that the aligner at the far end can lock to. It sits between the 64b/66b encoder and the SerDes TX parallel interface. When upstream has no block ready, it inserts an idle block so the line never carries garbage.

Parameters:
DATA_WIDTH, 64, block payload width; only 64 is supported.
HDR_WIDTH, 2, sync header width; only 2 is supported.
SERDES_WIDTH, 64, SerDes parallel word width; only 64 is supported.
SCRAMBLER_DISABLE, 0, if 1 the payload passes unscrambled (bring-up and test only).

Ports:
clk  in  1  single clock; all logic is in this domain.
rst_n  in  1  asynchronous, active-low reset.
i_tx_data  in  64  block payload; bit 0 is transmitted first.
i_tx_hdr  in  2  sync header; 01 = data, 10 = control.
i_tx_valid  in  1  a block is offered.
o_tx_ready  out  1  the block is accepted this cycle when valid and ready are both 1.
o_serdes_tx  out  64  SerDes word; bit 0 is transmitted first.
o_tx_underflow  out  1  one-cycle pulse when an idle block was inserted.
o_tx_hdr_err  out  1  one-cycle pulse when an accepted header was 00 or 11.

Behaviour:
- Reset values (applied asynchronously):
  - o_serdes_tx = 0; o_tx_underflow = 0; o_tx_hdr_err = 0.
  - seq = 0; residual buffer = 0 with length 0.
  - Scrambler state = 58'h3FF_FFFF_FFFF_FFFF.
- Sequence counter seq is 6 bits, 0..32, wrapping 32 -> 0. It advances every cycle after reset; upstream never stalls it.
- o_tx_ready = (seq != 32). It is decoded from registered seq only, with no combinational path from i_tx_valid.
- Block slot, seq 0..31:
  - Consume one block: the offered block if i_tx_valid is 1; otherwise the idle block.
  - Idle block: hdr 10, payload 64'h0000_0000_0000_001E. Inserting it pulses o_tx_underflow for one cycle.
  - Bit order in the 66-bit block: hdr[0], hdr[1], then scrambled payload bit 0..63.
  - Output word = low 64 bits of {block, residual}. The remaining bits become the new residual.
  - Residual length after slot k is 2*(k+1).
- Pause slot, seq 32:
  - The residual holds exactly 64 bits; output it as the word.
  - No block is consumed; the residual length becomes 0.
  - The scrambler state holds.
- Latency: a block accepted in cycle N starts appearing on o_serdes_tx in cycle N+1 (registered output). There is no other pipeline stage.
- Scrambler:
  - Self-synchronous, polynomial x^58 + x^39 + 1, applied to the payload only; the header is never scrambled.
  - Per bit, in transmit order: s = d ^ S[38] ^ S[57], then shift s into S[0].
  - All 64 bits are computed in parallel in one cycle.
  - State advances for every consumed block, including inserted idles.
  - With SCRAMBLER_DISABLE = 1 the payload is passed through and the state is don't-care.
- Header check:
  - An accepted hdr of 00 or 11 pulses o_tx_hdr_err for one cycle.
  - The block is still transmitted unchanged, so the far-end aligner sees a bad header.
  - Inserted idles never raise o_tx_hdr_err.
- Simultaneous events: i_tx_valid while seq = 32 is ignored. The block is not consumed and upstream must hold it.
- Reset mid-stream: all state clears immediately. The output restarts at seq 0 with no partial word. The far-end aligner is expected to lose and regain lock.
- Steady stream: exactly 1 cycle in 33 has o_tx_ready = 0.

Decomposition:
- Shared package eth_phy_10g_pkg, holding:
  - SYNC_DATA = 2'b01 and SYNC_CTRL = 2'b10.
  - BLOCK_TYPE_IDLE = 8'h1E.
  - SCR_WIDTH = 58, SCR_TAP_A = 38, SCR_TAP_B = 57.
  - SCR_INIT = 58'h3FF_FFFF_FFFF_FFFF.
  - GEARBOX_PERIOD = 33.
- One sub-module, eth_phy_10g_tx_scrambler:
  - Contains the 64-bit parallel scrambler and its 58-bit state register.
  - Has an advance-enable input.
  - Can be reused by a later RX descrambler bench model.
- Gearbox, residual buffer, sequence counter and idle insertion remain in the top module.

Test Plan:
- Reset check: assert rst_n = 0 mid-cycle -> o_serdes_tx, o_tx_underflow and o_tx_hdr_err go to 0 immediately. After release, o_tx_ready = 1.
- Continuous stream, SCRAMBLER_DISABLE = 1, 32 blocks with hdr 01 and payload = block index -> 33 output words concatenate to the 32 blocks in order. o_tx_ready = 0 exactly at cycles 32, 65, 98, ...
- Underflow: drop i_tx_valid for slots 5 and 6 -> o_tx_underflow pulses twice. Those slots decode as hdr 10 with payload 0x1E; following blocks are unshifted.
- Scrambler, SCRAMBLER_DISABLE = 0, all-zero payloads -> first payload matches the bench serial LFSR model seeded with SCR_INIT. A bench descrambler recovers zeros across 200 blocks.
- Bad header: send hdr 11 in slot 3 -> o_tx_hdr_err pulses in that cycle, and 11 appears at the correct bit offset in the output stream.
- Far-end lock: loop o_serdes_tx through a bench random bit rotation into the RX frame aligner -> block lock asserts within 66 × 64 blocks.
